// File: rtl/cache_control_if.sv
// cache_control_if: CPU, cache and memory signals of the miss-handling sequencer.
// master = controller side, slave = CPU/cache/memory side.
// Tag width is MEM_ADDR_W-10; the index is always the low 10 address bits.
interface cache_control_if #(
  parameter int MEM_ADDR_W = 30
);
  // CPU load/store port
  logic                  cpu_valid;
  logic                  cpu_we;
  logic [MEM_ADDR_W-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_done;
  logic [31:0]           cpu_rdata;
  logic                  cpu_err;
  // cache command/response port
  logic [MEM_ADDR_W-1:0] c_addr;
  logic [31:0]           c_wdata;
  logic                  c_rd;
  logic                  c_wr;
  logic                  c_sub;
  logic [31:0]           c_sub_data;
  logic [31:0]           c_rdata;
  logic                  c_r_hit;
  logic                  c_r_miss;
  logic                  c_w_hit;
  logic                  c_w_miss;
  logic                  c_dirty;
  logic [31:0]           c_wb_data;
  logic [MEM_ADDR_W-11:0] c_wb_tag;
  logic                  c_sub_fin;
  // external memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata, cpu_err,
    output c_addr, c_wdata, c_rd, c_wr, c_sub, c_sub_data,
    input  c_rdata, c_r_hit, c_r_miss, c_w_hit, c_w_miss,
    input  c_dirty, c_wb_data, c_wb_tag, c_sub_fin,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
    input  c_addr, c_wdata, c_rd, c_wr, c_sub, c_sub_data,
    output c_rdata, c_r_hit, c_r_miss, c_w_hit, c_w_miss,
    output c_dirty, c_wb_data, c_wb_tag, c_sub_fin,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_control.sv
// cache_control: one-at-a-time miss sequencer (lookup, write-back, fill, substitute, replay).
// Latency: load hit 2 cycles, store hit 3; misses add WB/FILL memory waits plus SUB/SUBW and replay.
// Backpressure: cpu_ready only in IDLE; WB/FILL hold mem_req until mem_ack. CACHE_CTRL_STATS_EN adds hit/miss/wb counters.
module cache_control #(
  parameter int MEM_ADDR_W = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_if.master      bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_wb
`endif
);

  localparam int TAG_W = MEM_ADDR_W - 10;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WCHK, MISS, WB, FILL, SUB, SUBW, DONE
  } state_t;

  state_t                state, state_n;
  logic [MEM_ADDR_W-1:0] req_addr;
  logic                  req_we;
  logic [31:0]           req_wdata;
  logic                  replay;
  logic                  err;
  logic [31:0]           vic_data;
  logic [TAG_W-1:0]      vic_tag;
  logic [31:0]           fill_data;
  logic [31:0]           rdata_q;

  // Registered request/victim/fill values feed the buses directly.
  assign bus.c_addr     = req_addr;
  assign bus.c_wdata    = req_wdata;
  assign bus.c_sub_data = fill_data;
  assign bus.cpu_rdata  = rdata_q;

  // State register; reset aborts any transaction and drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode and state-decoded strobes.
  always_comb begin
    state_n       = state;
    bus.cpu_ready = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.cpu_err   = 1'b0;
    bus.c_rd      = 1'b0;
    bus.c_wr      = 1'b0;
    bus.c_sub     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_valid) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (req_we) begin
          bus.c_wr = 1'b1;
          state_n  = WCHK;
        end else begin
          bus.c_rd = 1'b1;
          // Neither hit nor miss is an illegal cache answer: keep asking.
          if (bus.c_r_hit)       state_n = DONE;
          else if (bus.c_r_miss) state_n = MISS;
        end
      end
      WCHK: begin
        if (bus.c_w_hit)       state_n = DONE;
        else if (bus.c_w_miss) state_n = MISS;
      end
      MISS: begin
        if (replay)           state_n = DONE;
        else if (bus.c_dirty) state_n = WB;
        else                  state_n = FILL;
      end
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {vic_tag, req_addr[9:0]};
        bus.mem_wdata = vic_data;
        if (bus.mem_ack) state_n = FILL;
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = req_addr;
        if (bus.mem_ack) state_n = SUB;
      end
      SUB: begin
        bus.c_sub = 1'b1;
        state_n   = SUBW;
      end
      SUBW: begin
        if (bus.c_sub_fin) state_n = LOOKUP;
      end
      DONE: begin
        bus.cpu_done = 1'b1;
        bus.cpu_err  = err;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request, victim, fill and result registers plus the replay/error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      replay    <= 1'b0;
      err       <= 1'b0;
      vic_data  <= '0;
      vic_tag   <= '0;
      fill_data <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cpu_valid) begin
          req_addr  <= bus.cpu_addr;
          req_we    <= bus.cpu_we;
          req_wdata <= bus.cpu_wdata;
          replay    <= 1'b0;
        end
        LOOKUP: if (!req_we && bus.c_r_hit) rdata_q <= bus.c_rdata;
        // Victim is captured here, before c_sub can overwrite the line.
        MISS: begin
          if (replay) err <= 1'b1;
          else begin
            vic_data <= bus.c_wb_data;
            vic_tag  <= bus.c_wb_tag;
          end
        end
        FILL: if (bus.mem_ack) fill_data <= bus.mem_rdata;
        SUBW: if (bus.c_sub_fin) replay <= 1'b1;
        DONE: err <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  // First-pass hits, first-pass misses and completed write-backs; all wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit  <= '0;
      stat_miss <= '0;
      stat_wb   <= '0;
    end else begin
      if (!replay && ((state == LOOKUP && !req_we && bus.c_r_hit) ||
                      (state == WCHK && bus.c_w_hit)))
        stat_hit <= stat_hit + 32'd1;
      if (!replay && state != MISS && state_n == MISS)
        stat_miss <= stat_miss + 32'd1;
      if (state == WB && bus.mem_ack)
        stat_wb <= stat_wb + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed bench for cache_control with a one-line cache model and a delayed-ack memory.
// Expected completions are queued at issue time and checked by an independent monitor on cpu_done.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_control_if #(.MEM_ADDR_W(30)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hit, stat_miss, stat_wb;
`endif

  cache_control #(.MEM_ADDR_W(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss),
    .stat_wb   (stat_wb)
`endif
  );

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;

  // cache model: a single line plus victim fields set by the stimulus
  logic        pre_vld = 1'b0;
  logic [29:0] pre_a   = '0;
  logic [31:0] pre_d   = '0;
  logic        ent_v   = 1'b0;
  logic [29:0] ent_a   = '0;
  logic [31:0] ent_d   = '0;
  logic        force_miss = 1'b0;
  logic        vic_dirty  = 1'b0;
  logic [19:0] vic_tag    = '0;
  logic [31:0] vic_data   = '0;
  int          n_sub      = 0;
  // memory model
  logic [31:0] mem_val   = '0;
  int          mem_delay = 1;
  int          mem_cnt   = 0;
  int          n_mem     = 0;
  int          n_req_cyc = 0;
  logic        log_we    [64];
  logic [29:0] log_addr  [64];
  logic [31:0] log_wdata [64];

  logic ent_match;
  assign ent_match     = ent_v && (ent_a == bus.c_addr);
  assign bus.c_r_hit   = bus.c_rd && ent_match;
  assign bus.c_r_miss  = bus.c_rd && !ent_match;
  assign bus.c_rdata   = ent_d;
  assign bus.c_dirty   = vic_dirty;
  assign bus.c_wb_data = vic_data;
  assign bus.c_wb_tag  = vic_tag;
  assign bus.mem_rdata = mem_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: registered write hit/miss, substitute install, one-cycle c_sub_fin.
  always @(posedge clk) begin
    if (pre_vld) begin
      ent_v <= 1'b1; ent_a <= pre_a; ent_d <= pre_d;
    end else if (bus.c_sub && !force_miss) begin
      ent_v <= 1'b1; ent_a <= bus.c_addr; ent_d <= bus.c_sub_data;
    end else if (bus.c_wr && ent_match) begin
      ent_d <= bus.c_wdata;
    end
    bus.c_w_hit   <= bus.c_wr && ent_match;
    bus.c_w_miss  <= bus.c_wr && !ent_match;
    bus.c_sub_fin <= bus.c_sub;
    if (bus.c_sub) n_sub <= n_sub + 1;
  end

  // Memory model: ack after mem_delay request cycles, log every acknowledged access.
  always @(posedge clk) begin
    if (bus.mem_req) n_req_cyc <= n_req_cyc + 1;
    if (bus.mem_req && !bus.mem_ack) begin
      if (mem_cnt == mem_delay - 1) begin
        bus.mem_ack <= 1'b1; mem_cnt <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      bus.mem_ack <= 1'b0; mem_cnt <= 0;
    end
    if (bus.mem_req && bus.mem_ack) begin
      log_we[n_mem % 64]    <= bus.mem_we;
      log_addr[n_mem % 64]  <= bus.mem_addr;
      log_wdata[n_mem % 64] <= bus.mem_wdata;
      n_mem <= n_mem + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every cpu_done pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cpu_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got cpu_done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          chk("done_err", bus.cpu_err, e.err);
          if (e.chk_rdata) chk("done_rdata", bus.cpu_rdata, e.rdata);
          if (e.done_cyc >= 0) chk("done_latency", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic preload(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_a = a; pre_d = d; pre_vld = 1'b1;
    @(negedge clk);
    pre_vld = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [29:0] a, input logic [31:0] d,
                       input logic chk_rd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 50 && !bus.cpu_ready; i++) @(negedge clk);
    chk("issue_ready", bus.cpu_ready, 1'b1);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    e.chk_rdata = chk_rd;
    e.rdata     = exp_rd;
    e.err       = exp_err;
    e.done_cyc  = (lat == 0) ? -1 : cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.cpu_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending completions expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : stim
    int r0, m0, s0, d0;
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cpu_ready", bus.cpu_ready, 1'b1);
    chk("rst_strobes", {bus.cpu_done, bus.cpu_err, bus.c_rd, bus.c_wr, bus.c_sub, bus.mem_req, bus.mem_we}, 7'd0);
    chk("rst_buses", {bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, bus.c_addr}, 124'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load hit: done two cycles after accept, no memory traffic.
    preload(30'h0000005, 32'hDEAD_BEEF);
    r0 = n_req_cyc;
    issue(1'b0, 30'h0000005, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
    wait_done();
    chk("hit_no_mem_req", n_req_cyc - r0, 0);

    // Clean load miss with 3-cycle ack.
    vic_dirty = 1'b0; mem_val = 32'h1234_5678; mem_delay = 3;
    m0 = n_mem; s0 = n_sub;
    issue(1'b0, 30'h0001234, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 10);
    wait_done();
    chk("clean_mem_count", n_mem - m0, 1);
    chk("clean_fill_we", log_we[m0 % 64], 1'b0);
    chk("clean_fill_addr", log_addr[m0 % 64], 30'h0001234);
    chk("clean_sub_pulses", n_sub - s0, 1);

    // Store miss with dirty victim: WB, FILL, SUB, replayed store.
    vic_dirty = 1'b1; vic_tag = 20'h00ABC; vic_data = 32'h5555_0000;
    mem_delay = 2; mem_val = 32'h0BAD_F00D;
    m0 = n_mem;
    issue(1'b1, 30'h0012045, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 14);
    wait_done();
    chk("dirty_mem_count", n_mem - m0, 2);
    chk("wb_we", log_we[m0 % 64], 1'b1);
    chk("wb_addr", log_addr[m0 % 64], 30'h02AF045);
    chk("wb_wdata", log_wdata[m0 % 64], 32'h5555_0000);
    chk("wb_fill_addr", log_addr[(m0 + 1) % 64], 30'h0012045);
    chk("replay_store_data", ent_d, 32'hA5A5_A5A5);

    // Store hit on the line just allocated.
    issue(1'b1, 30'h0012045, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0, 3);
    wait_done();
    chk("store_hit_data", ent_d, 32'h0F0F_0F0F);

    // Replay misses again: error completion, single fill.
    vic_dirty = 1'b0; force_miss = 1'b1; mem_delay = 1;
    m0 = n_mem;
    issue(1'b0, 30'h0003333, 32'h0, 1'b0, 32'h0, 1'b1, 9);
    wait_done();
    force_miss = 1'b0;
    chk("err_one_fill", n_mem - m0, 1);

    // Reset asserted during FILL.
    mem_delay = 5;
    issue(1'b0, 30'h0004444, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 50 && !bus.mem_req; i++) @(negedge clk);
    chk("abort_in_fill", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_ready", bus.cpu_ready, 1'b1);
    chk("abort_c_sub", bus.c_sub, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

`ifdef CACHE_CTRL_STATS_EN
    // Two hits, then a dirty load miss; the replay hit is not counted.
    preload(30'h0000100, 32'h1111_2222);
    issue(1'b0, 30'h0000100, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 2);
    issue(1'b0, 30'h0000100, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 2);
    vic_dirty = 1'b1; vic_tag = 20'h00001; vic_data = 32'h0000_0077;
    mem_delay = 1; mem_val = 32'h9999_8888;
    issue(1'b0, 30'h0000200, 32'h0, 1'b1, 32'h9999_8888, 1'b0, 10);
    wait_done();
    chk("stat_hit", stat_hit, 32'd2);
    chk("stat_miss", stat_miss, 32'd1);
    chk("stat_wb", stat_wb, 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_control.md
# cache_control

Miss-handling sequencer placed between the CPU load/store port, the 4-way write-back data cache and the external memory port. It accepts one CPU access at a time and runs it through cache lookup. On a miss it writes back the dirty victim word, fetches the missing word from memory, installs it through the cache's substitute port, and replays the access. It also drives the cache's rd/wr/substitute controls, so the cache never sees overlapping commands.

## Interface
- `MEM_ADDR_W`, default 30: word-address width; the index is bits [9:0] and the tag is bits [MEM_ADDR_W-1:10].
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `cpu_valid`, in, 1: CPU request present.
- `cpu_we`, in, 1: 1 = store, 0 = load.
- `cpu_addr`, in, 30: word address.
- `cpu_wdata`, in, 32: store data.
- `cpu_ready`, out, 1: the controller can accept a request (high only in IDLE).
- `cpu_done`, out, 1: one-cycle completion pulse.
- `cpu_rdata`, out, 32: load result; valid while `cpu_done` is high and held until the next `cpu_done`.
- `cpu_err`, out, 1: pulses together with `cpu_done` when the replay misses again.
- `c_addr`, out, 30: cache address (the latched request address).
- `c_wdata`, out, 32: cache write data.
- `c_rd`, out, 1: cache read strobe.
- `c_wr`, out, 1: cache write strobe.
- `c_sub`, out, 1: cache substitute strobe.
- `c_sub_data`, out, 32: fill word.
- `c_rdata`, in, 32: cache read data.
- `c_r_hit`, in, 1: read hit (combinational from the cache).
- `c_r_miss`, in, 1: read miss (combinational from the cache).
- `c_w_hit`, in, 1: write hit (registered in the cache).
- `c_w_miss`, in, 1: write miss (registered in the cache).
- `c_dirty`, in, 1: victim dirty bit.
- `c_wb_data`, in, 32: victim data.
- `c_wb_tag`, in, 20: victim tag.
- `c_sub_fin`, in, 1: substitute-complete flag.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, 30: memory word address.
- `mem_wdata`, out, 32: memory write data.
- `mem_rdata`, in, 32: memory read data.
- `mem_ack`, in, 1: one-cycle memory completion.

## Operation
- States: IDLE, LOOKUP, WCHK, MISS, WB, FILL, SUB, SUBW, DONE.
- **IDLE**
  - `cpu_ready`=1.
  - On `cpu_valid`, latch addr/we/wdata into the request register, clear the replay flag, go to LOOKUP.
- **LOOKUP**
  - Load: `c_rd`=1. On `c_r_hit`, latch `c_rdata` and go to DONE. On `c_r_miss`, go to MISS.
  - Store: `c_wr`=1 for exactly this cycle, then go to WCHK.
- **WCHK** (store only): `c_w_hit` → DONE; `c_w_miss` → MISS.
- **MISS**
  - If the replay flag is already set: set err and go to DONE.
  - Otherwise, register `c_dirty`, `c_wb_data` and `c_wb_tag` into the victim register.
  - Dirty victim → WB; clean victim → FILL.
- **WB**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, req index}, `mem_wdata`=victim data.
  - Hold until `mem_ack`, then go to FILL.
- **FILL**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=req addr.
  - On `mem_ack`, latch `mem_rdata` into the fill register and go to SUB.
- **SUB**: `c_sub`=1 for exactly one cycle with `c_sub_data`=fill register, then go to SUBW.
- **SUBW**: wait for `c_sub_fin`, then set the replay flag and go to LOOKUP.
- **DONE**
  - `cpu_done`=1 and `cpu_err`=err, each for one cycle.
  - Clear err and go to IDLE.
- Write policy is write-allocate: a store miss fills first, then replays the store.

Boundary conditions:
- `mem_ack` outside WB/FILL is ignored.
- `cpu_valid` outside IDLE is ignored; the CPU holds it until it sees `cpu_ready`.
- `c_r_hit` and `c_r_miss` both low in LOOKUP (cache illegal) → stay in LOOKUP.
- Fill data and victim data never alias: the victim register is captured in MISS, before `c_sub` is issued.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from CPU inputs to outputs.
- Reset values:
  - state = IDLE, `cpu_ready`=1.
  - All other 1-bit outputs = 0.
  - `cpu_rdata`, `c_*` buses and `mem_*` buses = 0.
- Load hit: accept at edge 0; LOOKUP in cycle 1; `cpu_done` in cycle 2.
- Store hit: `cpu_done` in cycle 3 (LOOKUP, WCHK, DONE).
- Clean load miss: 2 (LOOKUP, MISS) + (FILL wait + 1) + 1 (SUB) + SUBW wait + 2 (replay LOOKUP, DONE).
- Dirty load miss: as above, plus the WB wait.
- `mem_req` stays high and `mem_addr`/`mem_wdata` stay stable from entering WB/FILL through the `mem_ack` cycle inclusive; `mem_req` is 0 in the cycle after `mem_ack`.
- `rst_n` low mid-transaction:
  - Immediate return to IDLE; all strobes (`mem_req`, `c_sub`, `c_wr`) drop asynchronously.
  - No `cpu_done` is issued for the aborted request.

## Configuration
- `CACHE_CTRL_STATS_EN` defined: adds outputs `stat_hit`, `stat_miss` and `stat_wb`, 32 bits each, reset to 0 and wrapping at 2^32-1 → 0.
  - `stat_hit` increments on a hit seen in LOOKUP (load) or WCHK (store) on the first pass.
  - `stat_miss` increments on each entry to MISS with the replay flag clear.
  - `stat_wb` increments on each WB `mem_ack`.
- `CACHE_CTRL_STATS_EN` undefined: these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Load 0x0000_0005 after the cache is preloaded with 0xDEAD_BEEF at that address → `cpu_done` 2 cycles after accept, `cpu_rdata`=0xDEAD_BEEF, `mem_req` never high.
- Load a miss, victim clean, memory returns 0x1234_5678 with a 3-cycle ack delay → one FILL request at `mem_addr`=request address, exactly one `c_sub` pulse, `cpu_rdata`=0x1234_5678, `cpu_err`=0.
- Store 0xA5A5_A5A5 that misses, victim dirty with tag 0x00ABC and data 0x5555_0000 → WB at `mem_addr`={0x00ABC, index} with `mem_wdata`=0x5555_0000, then FILL, SUB, then replay `c_wr` with 0xA5A5_A5A5, then `cpu_done`.
- Cache model forced to miss again on replay → `cpu_done`=1 with `cpu_err`=1, one memory fill only.
- Assert `rst_n`=0 during FILL with `mem_req` high → `mem_req`=0 within the same cycle, state IDLE, `cpu_ready`=1, no `cpu_done`.
- With `CACHE_CTRL_STATS_EN`: 2 hits, then 1 dirty miss → `stat_hit`=2, `stat_miss`=1, `stat_wb`=1; the replay hit does not increment `stat_hit`.
